// File: rtl/pe_spad_pkg.sv
// Shared definitions for the PE scratchpads (filter, ifmap, psum).
// Holds the read-sequencer state encoding, bank select type and default geometry.
package pe_spad_pkg;

    localparam int SPAD_DATA_W = 8;
    localparam int SPAD_DEPTH  = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    typedef logic bank_sel_t;

endpackage

// File: rtl/filter_spad_pingpong_if.sv
// Loader-side and MAC-side signals of the ping-pong filter scratchpad.
// The master drives words, configuration and back-pressure; the slave is the scratchpad.
interface filter_spad_pingpong_if #(
    parameter int DATA_W = pe_spad_pkg::SPAD_DATA_W,
    parameter int REP_W  = 8
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic [REP_W-1:0]  cfg_repeat;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_done;
    logic [1:0]        bank_full;

    modport master (
        output wr_valid, wr_data, wr_last, cfg_repeat, stall,
        input  wr_ready, out_valid, out_data, out_last, out_done, bank_full
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, cfg_repeat, stall,
        output wr_ready, out_valid, out_data, out_last, out_done, bank_full
    );
endinterface

// File: rtl/filter_spad_bank.sv
// One filter bank: DATA_W x DEPTH, one write port and one synchronous read port.
// rdata is a register that only updates on rd_en, so it holds while the reader is stalled.
module filter_spad_bank import pe_spad_pkg::*; #(
    parameter int DATA_W = SPAD_DATA_W,
    parameter int DEPTH  = SPAD_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // NOTE: the array has no reset so it can map onto a RAM macro; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/filter_spad_pingpong.sv
// Double-buffered filter scratchpad: the loader fills one bank while the read
// sequencer replays the other cfg_repeat times, with MAC stall support.
module filter_spad_pingpong import pe_spad_pkg::*; #(
    parameter int DATA_W = SPAD_DATA_W,
    parameter int DEPTH  = SPAD_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int REP_W  = 8
) (
    input logic                  clk,
    input logic                  rst,
    filter_spad_pingpong_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    bank_sel_t         wsel_q, wsel_d;
    bank_sel_t         rsel_q, rsel_d;
    bank_sel_t         osel_q, osel_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [1:0]        full_q, full_d;
    logic [ADDR_W:0]   len_q [2];
    logic [ADDR_W:0]   len_d [2];

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [REP_W-1:0]  pass_q, pass_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [ADDR_W:0]   rlen_q, rlen_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              out_done_q, out_done_d;

    logic              wr_accept;
    logic              wr_close;
    logic              rd_fire;
    logic              rd_last;
    logic              rd_done;
    logic [1:0]        bank_wr_en;
    logic [1:0]        bank_rd_en;
    logic [DATA_W-1:0] bank_rdata [2];

    // NOTE: always_comb uses blocking '=' and gives every _d a default first, so no latch is inferred.
    always_comb begin
        wr_accept = bus.wr_valid && !full_q[wsel_q];
        wr_close  = wr_accept && (bus.wr_last || (wcnt_q == LAST_ADDR));
        rd_fire   = (state_q == RD_READ) && !bus.stall;
        rd_last   = ({1'b0, raddr_q} == (rlen_q - LEN_ONE));
        rd_done   = rd_last && (pass_q == (rep_q - REP_ONE));

        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        osel_d      = osel_q;
        wcnt_d      = wcnt_q;
        full_d      = full_q;
        len_d       = len_q;
        state_d     = state_q;
        raddr_d     = raddr_q;
        pass_d      = pass_q;
        rep_d       = rep_q;
        rlen_d      = rlen_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_done_d  = out_done_q;

        bank_wr_en         = '0;
        bank_wr_en[wsel_q] = wr_accept;
        bank_rd_en         = '0;
        bank_rd_en[rsel_q] = rd_fire;

        if (wr_accept) begin
            wcnt_d = wcnt_q + ADDR_ONE;
            if (wr_close) begin
                full_d[wsel_q] = 1'b1;
                len_d[wsel_q]  = {1'b0, wcnt_q} + LEN_ONE;
                wcnt_d         = '0;
                wsel_d         = ~wsel_q;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (!bus.stall) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_done_d  = 1'b0;
                end
                if (full_q[rsel_q]) begin
                    state_d = RD_READ;
                    raddr_d = '0;
                    pass_d  = '0;
                    rlen_d  = len_q[rsel_q];
                    rep_d   = (bus.cfg_repeat == '0) ? REP_ONE : bus.cfg_repeat;
                end
            end
            RD_READ: begin
                if (rd_fire) begin
                    out_valid_d = 1'b1;
                    out_last_d  = rd_last;
                    out_done_d  = rd_done;
                    osel_d      = rsel_q;
                    // Pass wrap reuses the same cycle, so replay has no bubble.
                    if (rd_last) begin
                        raddr_d = '0;
                        pass_d  = pass_q + REP_ONE;
                    end else begin
                        raddr_d = raddr_q + ADDR_ONE;
                    end
                    if (rd_done) begin
                        full_d[rsel_q] = 1'b0;
                        rsel_d         = ~rsel_q;
                        state_d        = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            osel_q      <= 1'b0;
            wcnt_q      <= '0;
            full_q      <= '0;
            len_q       <= '{default: '0};
            state_q     <= RD_IDLE;
            raddr_q     <= '0;
            pass_q      <= '0;
            rep_q       <= REP_ONE;
            rlen_q      <= LEN_ONE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_done_q  <= 1'b0;
        end else begin
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            osel_q      <= osel_d;
            wcnt_q      <= wcnt_d;
            full_q      <= full_d;
            len_q       <= len_d;
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            pass_q      <= pass_d;
            rep_q       <= rep_d;
            rlen_q      <= rlen_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_done_q  <= out_done_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        filter_spad_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .wr_en (bank_wr_en[b]),
            .waddr (wcnt_q),
            .wdata (bus.wr_data),
            .rd_en (bank_rd_en[b]),
            .raddr (raddr_q),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.wr_ready  = !full_q[wsel_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = bank_rdata[osel_q];
    assign bus.out_last  = out_last_q;
    assign bus.out_done  = out_done_q;
    assign bus.bank_full = full_q;
endmodule

// File: tb/tb_filter_spad_pingpong.sv
// Scoreboard bench for filter_spad_pingpong: each closed row pushes its replay
// stream to a queue, and a negedge monitor pops and compares every new output word.
module tb_filter_spad_pingpong;
    import pe_spad_pkg::*;

    localparam int DATA_W = SPAD_DATA_W;
    localparam int DEPTH  = SPAD_DEPTH;
    localparam int REP_W  = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    filter_spad_pingpong_if #(.DATA_W(DATA_W), .REP_W(REP_W)) bus ();

    filter_spad_pingpong #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REP_W  (REP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [DATA_W-1:0] row_buf[$];
    int   model_wcnt = 0;

    int   cyc = 0;
    logic rst_s = 1'b1;
    logic stall_s = 1'b0;
    int   words_seen = 0;
    int   done_cyc = -1;
    int   last_gap = -1;
    logic prev_done = 1'b0;
    logic ready_at_done = 1'b0;
    int   stall_valid_cycles = 0;
    exp_t mon_e;
    logic pv = 1'b0, pl = 1'b0, pd = 1'b0;
    logic [DATA_W-1:0] pdata = '0;

    always @(posedge clk) begin
        cyc++;
        rst_s   = rst;
        stall_s = bus.stall;
    end

    // Monitor: during a stall the outputs must hold; otherwise out_valid marks a new word.
    always @(negedge clk) begin
        if (!rst_s) begin
            if (stall_s) begin
                checks++;
                if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_done} !== {pv, pdata, pl, pd}) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b dn=%b, want v=%b d=%h l=%b dn=%b",
                             bus.out_valid, bus.out_data, bus.out_last, bus.out_done, pv, pdata, pl, pd);
                end
                if (bus.out_valid === 1'b1) stall_valid_cycles++;
            end else if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got d=%h, want no output", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.out_data, bus.out_last, bus.out_done} !== mon_e) begin
                        errors++;
                        $display("FAIL stream_word: got d=%h last=%b done=%b, want d=%h last=%b done=%b",
                                 bus.out_data, bus.out_last, bus.out_done, mon_e.data, mon_e.last, mon_e.done);
                    end
                end
                if (prev_done) last_gap = cyc - done_cyc;
                prev_done = bus.out_done;
                if (bus.out_done === 1'b1) begin
                    done_cyc      = cyc;
                    ready_at_done = bus.wr_ready;
                end
                words_seen++;
            end
        end
        pv    = bus.out_valid;
        pdata = bus.out_data;
        pl    = bus.out_last;
        pd    = bus.out_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.stall      = 1'b0;
        bus.cfg_repeat = REP_W'(1);
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        row_buf.delete();
        model_wcnt = 0;
        prev_done  = 1'b0;
        done_cyc   = -1;
        last_gap   = -1;
    endtask

    task automatic close_row(input int rep);
        exp_t e;
        int   r;
        int   n;
        r = (rep == 0) ? 1 : rep;
        n = row_buf.size();
        for (int p = 0; p < r; p++) begin
            for (int i = 0; i < n; i++) begin
                e.data = row_buf[i];
                e.last = (i == n - 1);
                e.done = (i == n - 1) && (p == r - 1);
                exp_q.push_back(e);
            end
        end
        row_buf.delete();
        model_wcnt = 0;
    endtask

    task automatic load_row(input int n, input logic [DATA_W-1:0] base, input bit use_last, output int waits);
        logic [DATA_W-1:0] d;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (bus.wr_ready !== 1'b1 && guard < 500) begin
                tick();
                guard++;
                waits++;
            end
            if (guard >= 500) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: got wr_ready=0 for 500 cycles, want wr_ready=1");
                return;
            end
            d            = base + DATA_W'(i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = d;
            bus.wr_last  = use_last && (i == n - 1);
            tick();
            row_buf.push_back(d);
            model_wcnt++;
            if (bus.wr_last || model_wcnt == DEPTH) close_row(int'(bus.cfg_repeat));
            bus.wr_valid = 1'b0;
            bus.wr_last  = 1'b0;
        end
    endtask

    task automatic wait_words(input int target, input string name);
        int guard = 0;
        while (words_seen < target && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (words_seen < target) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got %0d words, want %0d", name, words_seen, target);
        end
    endtask

    task automatic wait_drain(input string name, input logic [1:0] want_full);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words pending, want 0", name, exp_q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.bank_full !== want_full) begin
            errors++;
            $display("FAIL %s_full_after: got %b, want %b", name, bus.bank_full, want_full);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, want 0", bus.out_valid); end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, want 0", bus.out_last); end
        checks++;
        if (bus.out_done !== 1'b0) begin errors++; $display("FAIL rst_out_done: got %b, want 0", bus.out_done); end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h, want 00", bus.out_data); end
        checks++;
        if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full: got %b, want 00", bus.bank_full); end
        checks++;
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b, want 1", bus.wr_ready); end
    endtask

    task automatic test_fill_stream();
        int w;
        bus.cfg_repeat = REP_W'(2);
        load_row(5, 8'h11, 1'b1, w);
        @(negedge clk);
        #1;
        checks++;
        if (bus.bank_full !== 2'b01) begin errors++; $display("FAIL fill_full_flag: got %b, want 01", bus.bank_full); end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_latency_e1: got %b, want 0", bus.out_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_latency_e2: got %b, want 1", bus.out_valid); end
        wait_drain("fill", 2'b00);
    endtask

    task automatic test_auto_close();
        int w;
        int base_words;
        do_reset();
        bus.cfg_repeat = '0;
        base_words = words_seen;
        load_row(64, 8'h40, 1'b0, w);
        @(negedge clk);
        #1;
        checks++;
        if (bus.bank_full !== 2'b01) begin errors++; $display("FAIL auto_full_flag: got %b, want 01", bus.bank_full); end
        checks++;
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL auto_wsel_ready: got %b, want 1", bus.wr_ready); end
        wait_drain("auto", 2'b00);
        checks++;
        if (words_seen - base_words != 64) begin
            errors++;
            $display("FAIL auto_word_count: got %0d, want 64", words_seen - base_words);
        end
    endtask

    task automatic test_ping_pong();
        int w0, w1;
        int guard;
        int early_ready;
        do_reset();
        bus.cfg_repeat = REP_W'(3);
        load_row(8, 8'hA0, 1'b1, w0);
        load_row(6, 8'hB0, 1'b1, w1);
        checks++;
        if (w1 != 0) begin errors++; $display("FAIL pp_bank1_waits: got %0d, want 0", w1); end
        @(negedge clk);
        #1;
        checks++;
        if (bus.bank_full !== 2'b11) begin errors++; $display("FAIL pp_both_full: got %b, want 11", bus.bank_full); end
        guard       = 0;
        early_ready = 0;
        while (last_gap == -1 && guard < 200) begin
            if (done_cyc == -1 && bus.wr_ready === 1'b1) early_ready++;
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (early_ready != 0) begin errors++; $display("FAIL pp_ready_early: got %0d cycles high, want 0", early_ready); end
        checks++;
        if (ready_at_done !== 1'b1) begin errors++; $display("FAIL pp_freed_ready: got %b, want 1", ready_at_done); end
        checks++;
        if (last_gap != 2) begin errors++; $display("FAIL pp_bubble_gap: got %0d, want 2", last_gap); end
        wait_drain("pp", 2'b00);
    endtask

    task automatic test_stall();
        int w;
        int base_words;
        int base_hold;
        bus.cfg_repeat = REP_W'(2);
        base_words = words_seen;
        load_row(10, 8'h30, 1'b1, w);
        wait_words(base_words + 4, "stall");
        base_hold = stall_valid_cycles;
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.stall = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall_valid_cycles - base_hold != 3) begin
            errors++;
            $display("FAIL stall_valid_held: got %0d cycles, want 3", stall_valid_cycles - base_hold);
        end
        wait_drain("stall", 2'b00);
        checks++;
        if (words_seen - base_words != 20) begin
            errors++;
            $display("FAIL stall_word_count: got %0d, want 20", words_seen - base_words);
        end
    endtask

    task automatic test_back_pressure();
        int w;
        int bad_ready;
        do_reset();
        bus.cfg_repeat = REP_W'(4);
        load_row(4, 8'h50, 1'b1, w);
        load_row(4, 8'h60, 1'b1, w);
        @(negedge clk);
        #1;
        checks++;
        if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, want 0", bus.wr_ready); end
        bad_ready    = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        bus.wr_last  = 1'b1;
        repeat (3) begin
            tick();
            if (bus.wr_ready !== 1'b0) bad_ready++;
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        checks++;
        if (bad_ready != 0) begin errors++; $display("FAIL bp_ready_during: got %0d high, want 0", bad_ready); end
        checks++;
        if (bus.bank_full !== 2'b11) begin errors++; $display("FAIL bp_full_kept: got %b, want 11", bus.bank_full); end
        load_row(3, 8'h70, 1'b1, w);
        wait_drain("bp", 2'b00);
    endtask

    task automatic test_reset_mid_read();
        int w;
        int base_words;
        bus.cfg_repeat = REP_W'(2);
        base_words = words_seen;
        load_row(6, 8'h80, 1'b1, w);
        wait_words(base_words + 8, "midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        row_buf.delete();
        model_wcnt = 0;
        prev_done  = 1'b0;
        done_cyc   = -1;
        last_gap   = -1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, want 0", bus.out_valid); end
        checks++;
        if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL midrst_bank_full: got %b, want 00", bus.bank_full); end
        bus.cfg_repeat = REP_W'(1);
        load_row(4, 8'h91, 1'b1, w);
        @(negedge clk);
        #1;
        checks++;
        if (bus.bank_full !== 2'b01) begin errors++; $display("FAIL midrst_bank0: got %b, want 01", bus.bank_full); end
        wait_drain("midrst", 2'b00);
    endtask

    initial begin
        test_reset();
        test_fill_stream();
        test_auto_close();
        test_ping_pong();
        test_stall();
        test_back_pressure();
        test_reset_mid_read();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
